bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 2, SHALL set the idle cycles between a RAM read strobe and the bus load; legal range 0..15.
REQ-002 Parameter RST_SEL, default 8'd1, SHALL set the bus_sel value driven out of reset (instruction RAM, the fetch path).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req_valid  input  1  transfer request present.
REQ-006 Port: req_ready  output  1  controller can accept a request this cycle.
REQ-007 Port: req_src  input  8  bus source code: 0 DRAM, 1 IRAM, 2 DI, 3 RI, 4 BI, 5 S, 6 C1, 7 C2, 8 AR, 9 AC, 10 PC, 11 IR.
REQ-008 Port: req_dst  input  4  destination register code, same numbering 0..11.
REQ-009 Port: bus_sel  output  8  select code to the bus multiplexer.
REQ-010 Port: ld_en  output  12  one-hot destination load enable; bit k loads destination k from the bus.
REQ-011 Port: mem_rd  output  1  one-cycle read strobe to data RAM (src 0) or instruction RAM (src 1).
REQ-012 Port: done  output  1  one-cycle pulse on the transfer's load cycle.
REQ-013 Port: busy  output  1  high whenever the state is not IDLE.
REQ-014 Port: err  output  1  one-cycle illegal-request pulse; present only under REQ-033.

Function
REQ-015 FSM states SHALL be IDLE, MEM_RD, WAIT, XFER.
REQ-016 req_ready SHALL equal (state == IDLE).
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_src and req_dst are latched then.
REQ-018 On accept, bus_sel SHALL take req_src at the same edge and hold it until the next accept.
REQ-019 IDLE + accept, src 2..11 (or >11 with checking off) -> XFER; done and ld_en in cycle N+1 when accepted at edge N.
REQ-020 IDLE + accept, src 0 or 1 -> MEM_RD; mem_rd = 1 for exactly that cycle.
REQ-021 MEM_RD -> WAIT if MEM_WAIT > 0, otherwise -> XFER.
REQ-022 WAIT SHALL last exactly MEM_WAIT cycles, counted by a 4-bit down-counter loaded on entry, then -> XFER.
REQ-023 Memory-source latency from accept edge to load cycle SHALL be MEM_WAIT + 2 cycles.
REQ-024 XFER SHALL last one cycle, assert done = 1 and ld_en = 1 << dst, then -> IDLE.
REQ-025 dst > 11 SHALL produce ld_en = 0 in XFER; done still pulses.
REQ-026 src == dst SHALL be legal and processed normally.
REQ-027 req_valid while busy SHALL be ignored without being latched; the requester holds it until accepted.
REQ-028 Back-to-back: a request valid in the XFER cycle SHALL NOT be accepted; it is accepted on the following edge (IDLE).
REQ-029 Outside XFER, ld_en SHALL be 0 and done SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, bus_sel = RST_SEL, ld_en = 0, mem_rd = 0, done = 0, err = 0, busy = 0, and wait counter = 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no ld_en or done pulse; no request is retained.
REQ-032 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro BUS_XFER_CHECK_EN defined: a request with src > 11 or dst > 11 SHALL be accepted, then produce a one-cycle err pulse in cycle N+1 with no ld_en, no done, no mem_rd, and return to IDLE; bus_sel keeps its previous value.
REQ-034 Macro BUS_XFER_CHECK_EN undefined: the err port SHALL be absent (tied 0) and such requests SHALL follow REQ-019/REQ-025.

Verification
REQ-035 Reset released, src 9, dst 3 -> bus_sel = 9 after edge N, ld_en = 12'h008 and done = 1 in cycle N+1, busy = 1 for that one cycle only.
REQ-036 MEM_WAIT = 2, src 0, dst 2 -> mem_rd in N+1, WAIT in N+2..N+3, ld_en = 12'h004 and done in N+4.
REQ-037 MEM_WAIT = 0, src 1, dst 11 -> mem_rd in N+1, ld_en = 12'h800 in N+2.
REQ-038 req_valid held high continuously with src 10/dst 8, then src 5/dst 4 -> second accept exactly one cycle after the first XFER, with no lost or duplicated ld_en.
REQ-039 rst_n pulled low during WAIT -> outputs reach reset values asynchronously; no done or ld_en until a new request.
REQ-040 With BUS_XFER_CHECK_EN, src 12 -> err = 1 in N+1 and ld_en = 0; without it, src 12, dst 2 -> bus_sel = 12, ld_en = 12'h004.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer bus controller: drives the bus mux select and one-hot destination loads,
// inserting a RAM read strobe plus MEM_WAIT idle cycles for memory sources. Macro BUS_XFER_CHECK_EN enables illegal-code checking.
module bus_xfer_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter logic [7:0]  RST_SEL  = 8'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_src,
    input  logic [3:0]  req_dst,
    output logic [7:0]  bus_sel,
    output logic [11:0] ld_en,
    output logic        mem_rd,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam int unsigned NUM_REG = 12;
    localparam logic [3:0]  WAIT_LOAD = 4'(MEM_WAIT);
    localparam logic [7:0]  MAX_SRC = 8'(NUM_REG - 1);
    localparam logic [3:0]  MAX_DST = 4'(NUM_REG - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        WAIT,
        XFER
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  dst, dst_next;
    logic        bad, bad_next;
    logic [7:0]  sel_next;
    logic [11:0] ld_next;
    logic        accept, illegal, rd_next, done_next, xfer_next;

    assign accept = req_valid && (state == IDLE);

`ifdef BUS_XFER_CHECK_EN
    assign illegal = (req_src > MAX_SRC) || (req_dst > MAX_DST);
`else
    assign illegal = 1'b0;
`endif

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dst_next   = dst;
        bad_next   = bad;
        sel_next   = bus_sel;
        case (state)
            IDLE: begin
                if (accept) begin
                    dst_next = req_dst;
                    bad_next = illegal;
                    if (illegal) begin
                        state_next = XFER;
                    end else begin
                        sel_next   = req_src;
                        state_next = (req_src < 8'd2) ? MEM_RD : XFER;
                    end
                end
            end
            MEM_RD: begin
                if (WAIT_LOAD != 4'd0) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = XFER;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) state_next = XFER;
            end
            XFER: begin
                state_next = IDLE;
                bad_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        rd_next   = (state == IDLE) && (state_next == MEM_RD);
        xfer_next = (state_next == XFER);
        done_next = xfer_next && !bad_next;
        ld_next   = 12'h000;
        if (done_next && (dst_next <= MAX_DST)) ld_next = 12'(12'h001 << dst_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            dst       <= 4'd0;
            bad       <= 1'b0;
            bus_sel   <= RST_SEL;
            ld_en     <= 12'h000;
            mem_rd    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dst       <= dst_next;
            bad       <= bad_next;
            bus_sel   <= sel_next;
            ld_en     <= ld_next;
            mem_rd    <= rd_next;
            done      <= done_next;
            busy      <= (state_next != IDLE);
            req_ready <= (state_next == IDLE);
        end
    end

`ifdef BUS_XFER_CHECK_EN
    // Illegal requests ride through XFER with loads suppressed and err raised instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= xfer_next && bad_next;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: main instance with MEM_WAIT=2, second with MEM_WAIT=0.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_src = 8'd0;
    logic [3:0]  req_dst = 4'd0;
    logic        req_ready, mem_rd, done, busy, err;
    logic [7:0]  bus_sel;
    logic [11:0] ld_en;

    logic        v0 = 1'b0;
    logic [7:0]  src0 = 8'd0;
    logic [3:0]  dst0 = 4'd0;
    logic        ready0, rd0, done0, busy0, err0;
    logic [7:0]  sel0;
    logic [11:0] ld0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  sel;
        logic [11:0] ld;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.MEM_WAIT(2), .RST_SEL(8'd1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .bus_sel(bus_sel), .ld_en(ld_en),
        .mem_rd(mem_rd), .done(done), .busy(busy), .err(err)
    );

    bus_xfer_ctrl #(.MEM_WAIT(0), .RST_SEL(8'd1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(ready0),
        .req_src(src0), .req_dst(dst0), .bus_sel(sel0), .ld_en(ld0),
        .mem_rd(rd0), .done(done0), .busy(busy0), .err(err0)
    );

    // Scoreboard: every done pulse pops one expected transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_done sel=%0d ld_en=%h", bus_sel, ld_en);
                end else begin
                    e = sb.pop_front();
                    if (ld_en !== e.ld || bus_sel !== e.sel) begin
                        bad++;
                        $display("FAIL sb_xfer sel=%0d ld_en=%h expected sel=%0d ld_en=%h",
                                 bus_sel, ld_en, e.sel, e.ld);
                    end
                end
            end else if (ld_en !== 12'h000) begin
                total++;
                bad++;
                $display("FAIL ld_en_outside_xfer ld_en=%h expected 000", ld_en);
            end
        end
    end

    // Presents a request at a negedge, holds it until accepted, returns 1ns after the accept edge.
    task automatic send(input logic [7:0] s, input logic [3:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout ready=%b expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (bus_sel !== 8'd1)   begin bad++; $display("FAIL rst_sel got=%0d exp=1", bus_sel); end
        total++; if (ld_en !== 12'h000)  begin bad++; $display("FAIL rst_ld got=%h exp=000", ld_en); end
        total++; if ({done, mem_rd, err} !== 3'b000)
            begin bad++; $display("FAIL rst_pulses got=%b exp=000", {done, mem_rd, err}); end
    endtask

    // First accept on the first edge after reset release; register source.
    task automatic test_reg_xfer();
        sb.push_back('{8'd9, 12'h008});
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_src   = 8'd9;
        req_dst   = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++; if (bus_sel !== 8'd9)  begin bad++; $display("FAIL reg_sel got=%0d exp=9", bus_sel); end
        total++; if (done !== 1'b1 || ld_en !== 12'h008)
            begin bad++; $display("FAIL reg_load done=%b ld_en=%h exp 1/008", done, ld_en); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL reg_busy got=%b exp=1", busy); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL reg_after busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_mem_wait();
        sb.push_back('{8'd0, 12'h004});
        send(8'd0, 4'd2);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (mem_rd !== (j == 0) || done !== (j == 3)) begin
                bad++;
                $display("FAIL mem_wait_step%0d mem_rd=%b done=%b exp %b/%b",
                         j, mem_rd, done, (j == 0), (j == 3));
            end
            if (j < 4) begin
                @(posedge clk);
                #1;
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mem_wait_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_mem_nowait();
        @(negedge clk);
        v0   = 1'b1;
        src0 = 8'd1;
        dst0 = 4'd11;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        total++; if (rd0 !== 1'b1 || done0 !== 1'b0)
            begin bad++; $display("FAIL nowait_rd mem_rd=%b done=%b exp 1/0", rd0, done0); end
        @(posedge clk);
        #1;
        total++; if (done0 !== 1'b1 || ld0 !== 12'h800 || rd0 !== 1'b0)
            begin bad++; $display("FAIL nowait_load done=%b ld_en=%h mem_rd=%b exp 1/800/0", done0, ld0, rd0); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        sb.push_back('{8'd10, 12'h100});
        sb.push_back('{8'd5, 12'h010});
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = 8'd10;
        req_dst   = 4'd8;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first done=%b exp=1", done); end
        @(negedge clk);
        req_src = 8'd5;
        req_dst = 4'd4;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0 || busy !== 1'b0 || bus_sel !== 8'd10)
            begin bad++; $display("FAIL b2b_gap done=%b busy=%b sel=%0d exp 0/0/10", done, busy, bus_sel); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++; if (done !== 1'b1 || ld_en !== 12'h010 || bus_sel !== 8'd5)
            begin bad++; $display("FAIL b2b_second done=%b ld_en=%h sel=%0d exp 1/010/5", done, ld_en, bus_sel); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_dup busy=%b exp=0", busy); end
    endtask

    task automatic test_edge_codes();
        sb.push_back('{8'd4, 12'h010});
        send(8'd4, 4'd4);
`ifdef BUS_XFER_CHECK_EN
        send(8'd3, 4'd13);
        total++; if (err !== 1'b1 || done !== 1'b0 || ld_en !== 12'h000)
            begin bad++; $display("FAIL dst13 err=%b done=%b ld_en=%h exp 1/0/000", err, done, ld_en); end
`else
        sb.push_back('{8'd3, 12'h000});
        send(8'd3, 4'd13);
        total++; if (done !== 1'b1 || ld_en !== 12'h000)
            begin bad++; $display("FAIL dst13 done=%b ld_en=%h exp 1/000", done, ld_en); end
`endif
    endtask

    task automatic test_src12();
`ifdef BUS_XFER_CHECK_EN
        logic [7:0] prev;
        @(negedge clk);
        prev = bus_sel;
        send(8'd12, 4'd2);
        total++; if (err !== 1'b1 || ld_en !== 12'h000 || done !== 1'b0 || mem_rd !== 1'b0 || bus_sel !== prev)
            begin bad++; $display("FAIL src12 err=%b ld_en=%h done=%b sel=%0d exp 1/000/0/%0d", err, ld_en, done, bus_sel, prev); end
        @(posedge clk);
        #1;
        total++; if (err !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL src12_end err=%b busy=%b exp 0/0", err, busy); end
`else
        sb.push_back('{8'd12, 12'h004});
        send(8'd12, 4'd2);
        total++; if (bus_sel !== 8'd12 || ld_en !== 12'h004 || err !== 1'b0)
            begin bad++; $display("FAIL src12 sel=%0d ld_en=%h err=%b exp 12/004/0", bus_sel, ld_en, err); end
`endif
    endtask

    task automatic test_reset_mid();
        send(8'd0, 4'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1 || bus_sel !== 8'd1 || mem_rd !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL mid_rst busy=%b ready=%b sel=%0d mem_rd=%b done=%b exp 0/1/1/0/0",
                                  busy, req_ready, bus_sel, mem_rd, done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || ld_en !== 12'h000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_rst_quiet%0d done=%b ld_en=%h busy=%b exp 0/000/0", k, done, ld_en, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reg_xfer();
        test_mem_wait();
        test_mem_nowait();
        test_back_to_back();
        test_edge_codes();
        test_src12();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
